// File: rtl/idma_axis_read_burst.sv
// rtl/idma_axis_read_burst.sv - multi-beat, multi-stream AXI-Stream read burst for the iDMA transport layer
// Optional tkeep framing check: define IDMA_AXIS_READ_BURST_TKEEP_EN.
module idma_axis_read_burst #(
  parameter int unsigned StrbWidth     = 16,
  parameter int unsigned NumStreams    = 2,
  parameter int unsigned BeatCntWidth  = 16,
  parameter int unsigned OffsetWidth   = $clog2(StrbWidth),
  parameter int unsigned StreamIdWidth = (NumStreams > 1) ? $clog2(NumStreams) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              r_dp_req_valid_i,
  output logic                              r_dp_req_ready_o,
  input  logic [OffsetWidth-1:0]            r_dp_req_offset_i,
  input  logic [OffsetWidth-1:0]            r_dp_req_tailer_i,
  input  logic [OffsetWidth-1:0]            r_dp_req_shift_i,
  input  logic [BeatCntWidth-1:0]           r_dp_req_num_beats_i,
  input  logic [StreamIdWidth-1:0]          r_dp_req_stream_i,
  output logic                              r_dp_rsp_valid_o,
  input  logic                              r_dp_rsp_ready_i,
  output logic                              r_dp_rsp_err_o,
  output logic                              r_dp_rsp_first_o,
  output logic                              r_dp_rsp_last_o,
  input  logic [NumStreams-1:0]             s_tvalid_i,
  output logic [NumStreams-1:0]             s_tready_o,
  input  logic [NumStreams*8*StrbWidth-1:0] s_tdata_i,
  input  logic [NumStreams-1:0]             s_tlast_i,
`ifdef IDMA_AXIS_READ_BURST_TKEEP_EN
  input  logic [NumStreams*StrbWidth-1:0]   s_tkeep_i,
`endif
  output logic [8*StrbWidth-1:0]            buffer_in_o,
  output logic [StrbWidth-1:0]              buffer_in_valid_o,
  input  logic [StrbWidth-1:0]              buffer_in_ready_i,
  output logic                              busy_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RSP} state_e;

  localparam logic [StrbWidth-1:0]   AllOnes = '1;
  localparam logic [OffsetWidth:0]   StrbW   = (OffsetWidth+1)'(StrbWidth);

  state_e                    r_state;
  state_e                    w_state_next;
  logic [OffsetWidth-1:0]    r_offset;
  logic [OffsetWidth-1:0]    r_tailer;
  logic [OffsetWidth-1:0]    r_shift;
  logic [StreamIdWidth-1:0]  r_stream;
  logic [BeatCntWidth-1:0]   r_cnt;
  logic                      r_err;
  logic                      r_first;

  logic                      w_last;
  logic [OffsetWidth:0]      w_tail_sh;
  logic [OffsetWidth:0]      w_rot_sh;
  logic [StrbWidth-1:0]      w_first_mask;
  logic [StrbWidth-1:0]      w_last_mask;
  logic [StrbWidth-1:0]      w_raw_mask;
  logic [StrbWidth-1:0]      w_mask_in;
  logic                      w_in_ready;
  logic                      w_sel_valid;
  logic                      w_sel_last;
  logic [8*StrbWidth-1:0]    w_sel_data;
  logic [StrbWidth-1:0]      w_sel_keep;
  logic [NumStreams-1:0]     w_tready;
  logic                      w_xfer;
  logic                      w_beat_err;

  assign w_last       = (r_cnt == '0);
  assign w_tail_sh    = StrbW - {1'b0, r_tailer};
  assign w_rot_sh     = StrbW - {1'b0, r_shift};
  assign w_first_mask = r_first ? (AllOnes << r_offset) : AllOnes;
  assign w_last_mask  = (w_last && (r_tailer != '0)) ? (AllOnes >> w_tail_sh) : AllOnes;
  assign w_raw_mask   = w_first_mask & w_last_mask;
  // Rotate right by shift; a zero shift makes the left term shift out completely.
  assign w_mask_in    = (w_raw_mask >> r_shift) | (w_raw_mask << w_rot_sh);
  assign w_in_ready   = &(buffer_in_ready_i | ~w_mask_in);

  // An out-of-range stream id matches no slice, so the burst simply stalls.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_sel_keep  = '1;
    w_tready    = '0;
    for (int k = 0; k < int'(NumStreams); k++) begin
      if (r_stream == StreamIdWidth'(k)) begin
        w_sel_valid = s_tvalid_i[k];
        w_sel_last  = s_tlast_i[k];
        w_sel_data  = s_tdata_i[k*8*StrbWidth +: 8*StrbWidth];
`ifdef IDMA_AXIS_READ_BURST_TKEEP_EN
        w_sel_keep  = s_tkeep_i[k*StrbWidth +: StrbWidth];
`endif
        w_tready[k] = (r_state == ACTIVE) && w_in_ready;
      end
    end
  end

  assign w_xfer = (r_state == ACTIVE) && w_sel_valid && w_in_ready;

  always_comb begin
    w_beat_err = w_sel_last ^ w_last;
`ifdef IDMA_AXIS_READ_BURST_TKEEP_EN
    w_beat_err = w_beat_err | (|(w_raw_mask & ~w_sel_keep));
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_dp_req_valid_i) w_state_next = ACTIVE;
      ACTIVE:  if (w_xfer && w_last) w_state_next = RSP;
      RSP:     if (r_dp_rsp_ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_offset <= '0;
      r_tailer <= '0;
      r_shift  <= '0;
      r_stream <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_first  <= 1'b1;
    end else if ((r_state == IDLE) && r_dp_req_valid_i) begin
      r_offset <= r_dp_req_offset_i;
      r_tailer <= r_dp_req_tailer_i;
      r_shift  <= r_dp_req_shift_i;
      r_stream <= r_dp_req_stream_i;
      r_cnt    <= r_dp_req_num_beats_i;
      r_err    <= 1'b0;
      r_first  <= 1'b1;
    end else if (w_xfer) begin
      r_first <= 1'b0;
      if (!w_last) r_cnt <= r_cnt - 1'b1;
      if (w_beat_err) r_err <= 1'b1;
    end
  end

  // Gate with reset so no ready is advertised while reset is held.
  assign r_dp_req_ready_o  = (r_state == IDLE) && rst_ni;
  assign r_dp_rsp_valid_o  = (r_state == RSP);
  assign r_dp_rsp_err_o    = r_err;
  assign r_dp_rsp_first_o  = 1'b1;
  assign r_dp_rsp_last_o   = 1'b1;
  assign s_tready_o        = w_tready;
  assign buffer_in_o       = w_sel_data;
  assign buffer_in_valid_o = w_xfer ? w_mask_in : '0;
  assign busy_o            = (r_state != IDLE);

endmodule

// File: tb/tb_idma_axis_read_burst.sv
// tb/tb_idma_axis_read_burst.sv - scoreboard testbench for idma_axis_read_burst
module tb_idma_axis_read_burst;
  localparam int SW = 16;
  localparam int NS = 2;

  typedef struct packed {
    logic [SW-1:0]   strb;
    logic [8*SW-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_offset, req_tailer, req_shift;
  logic [15:0]       req_nb;
  logic [0:0]        req_stream;
  logic              rsp_valid, rsp_ready, rsp_err, rsp_first, rsp_last;
  logic [NS-1:0]     s_tvalid, s_tready, s_tlast;
  logic [NS*8*SW-1:0] s_tdata;
  logic [8*SW-1:0]   buf_data;
  logic [SW-1:0]     buf_valid, buf_ready;
  logic              busy;

  exp_t              sb_q[$];
  bit                err_q[$];
  exp_t              e_pop;
  bit                err_pop;
  int                n_cmp = 0;
  int                n_bad = 0;
  logic [SW-1:0]     exp_m [8];
  bit                tl_pat [8];
  int                seq = 0;

  always #5 clk = ~clk;

  idma_axis_read_burst dut (
    .clk_i(clk), .rst_ni(rst_n),
    .r_dp_req_valid_i(req_valid), .r_dp_req_ready_o(req_ready),
    .r_dp_req_offset_i(req_offset), .r_dp_req_tailer_i(req_tailer),
    .r_dp_req_shift_i(req_shift), .r_dp_req_num_beats_i(req_nb),
    .r_dp_req_stream_i(req_stream),
    .r_dp_rsp_valid_o(rsp_valid), .r_dp_rsp_ready_i(rsp_ready),
    .r_dp_rsp_err_o(rsp_err), .r_dp_rsp_first_o(rsp_first), .r_dp_rsp_last_o(rsp_last),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata), .s_tlast_i(s_tlast),
    .buffer_in_o(buf_data), .buffer_in_valid_o(buf_valid), .buffer_in_ready_i(buf_ready),
    .busy_o(busy)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT pushes bytes or completes a response.
  always @(negedge clk) begin
    if (rst_n && buf_valid != '0) begin
      if (sb_q.size() == 0) chk("unexpected_push", {112'd0, buf_valid}, 128'd0);
      else begin
        e_pop = sb_q.pop_front();
        chk("strobe", {112'd0, buf_valid}, {112'd0, e_pop.strb});
        chk("data", buf_data, e_pop.data);
      end
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      if (err_q.size() == 0) chk("unexpected_rsp", 128'd1, 128'd0);
      else begin
        err_pop = err_q.pop_front();
        chk("rsp_err", {127'd0, rsp_err}, {127'd0, err_pop});
      end
    end
  end

  task automatic do_req(input int off, input int tl, input int sh, input int nb, input int s);
    bit ok;
    @(posedge clk); #1;
    req_offset = 4'(off); req_tailer = 4'(tl); req_shift = 4'(sh);
    req_nb = 16'(nb); req_stream = 1'(s); req_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("req_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic beat(input int s, input logic [8*SW-1:0] d, input bit l, input bit stall);
    bit ok;
    s_tvalid[s] = 1'b1;
    s_tlast[s] = l;
    s_tdata[s*8*SW +: 8*SW] = d;
    if (stall) begin
      buf_ready[5] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("bp_tready", {127'd0, s_tready[s]}, 128'd0);
        chk("bp_strobe", {112'd0, buf_valid}, 128'd0);
      end
      @(posedge clk); #1;
      buf_ready = '1;
    end
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_tready[s]) begin ok = 1; break; end
    end
    if (!ok) chk("beat_timeout", 128'd0, 128'd1);
    chk("tready_other", {126'd0, s_tready & ~(NS'(1) << s)}, 128'd0);
    @(posedge clk); #1;
    s_tvalid[s] = 1'b0;
    s_tlast[s] = 1'b0;
  endtask

  task automatic do_rsp(input int stall, input bit exp_err);
    bit ok;
    err_q.push_back(exp_err);
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) chk("rsp_timeout", 128'd0, 128'd1);
    for (int i = 0; i < stall; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", {127'd0, rsp_valid}, 128'd1);
      chk("stall_err", {127'd0, rsp_err}, {127'd0, exp_err});
      chk("stall_req_ready", {127'd0, req_ready}, 128'd0);
      chk("stall_tready", {126'd0, s_tready}, 128'd0);
      chk("stall_first_last", {126'd0, rsp_first, rsp_last}, 128'd3);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("busy_after_rsp", {127'd0, busy}, 128'd0);
    chk("req_ready_idle", {127'd0, req_ready}, 128'd1);
  endtask

  task automatic run_burst(input int off, input int tl, input int sh, input int nb, input int s,
                           input int stall_beat, input int n_send, input int rsp_stall,
                           input bit exp_err);
    logic [31:0]     w;
    logic [8*SW-1:0] d;
    do_req(off, tl, sh, nb, s);
    for (int b = 0; b < n_send; b++) begin
      seq++;
      w = 32'hA500_0000 + 32'(s << 16) + 32'(seq);
      d = {4{w}};
      sb_q.push_back({exp_m[b], d});
      beat(s, d, tl_pat[b], b == stall_beat);
    end
    if (n_send == nb + 1) do_rsp(rsp_stall, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_offset = '0; req_tailer = '0; req_shift = '0;
    req_nb = '0; req_stream = '0; rsp_ready = 1'b0; s_tvalid = '0; s_tlast = '0;
    s_tdata = {NS*8*SW/32{32'h5A5A_0F0F}}; buf_ready = '1;
    repeat (2) @(posedge clk); #1;
    chk("rst_req_ready", {127'd0, req_ready}, 128'd0);
    chk("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_tready", {126'd0, s_tready}, 128'd0);
    chk("rst_strobe", {112'd0, buf_valid}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {127'd0, req_ready}, 128'd1);

    // single beat: 0xFFF0 & 0x0FFF
    exp_m[0] = 16'h0FF0; tl_pat[0] = 1;
    run_burst(4, 12, 0, 0, 0, -1, 1, 0, 0);

    // four beats on stream 1, shift 2, backpressure on beat 1
    exp_m[0] = 16'h3FFE; exp_m[1] = 16'hFFFF; exp_m[2] = 16'hFFFF; exp_m[3] = 16'hC007;
    tl_pat[0] = 0; tl_pat[1] = 0; tl_pat[2] = 0; tl_pat[3] = 1;
    run_burst(3, 5, 2, 3, 1, 1, 4, 0, 0);

    // early tlast: all three beats still consumed
    exp_m[0] = 16'hFFFF; exp_m[1] = 16'hFFFF; exp_m[2] = 16'hFFFF;
    tl_pat[0] = 1; tl_pat[1] = 0; tl_pat[2] = 0;
    run_burst(0, 0, 0, 2, 0, -1, 3, 0, 1);

    // missing tlast on last beat, response stalled 5 cycles
    exp_m[0] = 16'h0FF0; exp_m[1] = 16'hF000;
    tl_pat[0] = 0; tl_pat[1] = 0;
    run_burst(8, 4, 4, 1, 1, -1, 2, 5, 1);

    // reset after 2 of 8 beats
    exp_m[0] = 16'hFFFC; exp_m[1] = 16'hFFFF;
    tl_pat[0] = 0; tl_pat[1] = 0;
    run_burst(2, 0, 0, 7, 1, -1, 2, 0, 0);
    s_tvalid[1] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {127'd0, busy}, 128'd0);
    chk("midrst_tready", {126'd0, s_tready}, 128'd0);
    chk("midrst_strobe", {112'd0, buf_valid}, 128'd0);
    chk("midrst_req_ready", {127'd0, req_ready}, 128'd0);
    chk("midrst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    s_tvalid = '0;
    repeat (2) @(posedge clk); #3;
    rst_n = 1'b1;
    exp_m[0] = 16'hFFC0; tl_pat[0] = 1;
    run_burst(6, 0, 0, 0, 0, -1, 1, 0, 0);

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", 128'(sb_q.size()), 128'd0);
    chk("rsp_q_empty", 128'(err_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
